// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one combinational ALU (control decoder + datapath) between two
// requesters. Each requester presents {funct7, alu_op, funct3, a, b} on a
// valid/ready handshake. One request is granted at a time, with round-robin
// fairness. The operation is issued to the ALU from a registered copy. The
// ALU result and zero flag are captured and returned on a per-requester
// response handshake.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous assert, active-low reset
//   reqN_valid_i / _ready_o  request handshake, N = 0, 1
//   reqN_funct7_i            funct7 select bit
//   reqN_alu_op_i            ALU_Op class
//   reqN_funct3_i            funct3
//   reqN_a_i, reqN_b_i       operands
//   rspN_valid_o / _ready_i  response handshake, N = 0, 1
//   rspN_result_o, _zero_o   captured result; both requesters see the same value
//   alu_*_o                  issue register driven to the shared ALU
//   alu_result_i, alu_zero_i combinational return from the shared ALU
//   busy_o                   high whenever the FSM is not idle
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; ready goes to the current winner only
// EXEC  | issue register drives the ALU; result captured at the end
// RESP  | response held for the owner until its rsp_ready_i is high
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic                  req0_funct7_i,
   input  logic [2:0]            req0_alu_op_i,
   input  logic [2:0]            req0_funct3_i,
   input  logic [DATA_WIDTH-1:0] req0_a_i,
   input  logic [DATA_WIDTH-1:0] req0_b_i,

   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic                  req1_funct7_i,
   input  logic [2:0]            req1_alu_op_i,
   input  logic [2:0]            req1_funct3_i,
   input  logic [DATA_WIDTH-1:0] req1_a_i,
   input  logic [DATA_WIDTH-1:0] req1_b_i,

   output logic                  rsp0_valid_o,
   input  logic                  rsp0_ready_i,
   output logic [DATA_WIDTH-1:0] rsp0_result_o,
   output logic                  rsp0_zero_o,

   output logic                  rsp1_valid_o,
   input  logic                  rsp1_ready_i,
   output logic [DATA_WIDTH-1:0] rsp1_result_o,
   output logic                  rsp1_zero_o,

   output logic                  alu_funct7_o,
   output logic [2:0]            alu_op_o,
   output logic [2:0]            alu_funct3_o,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_zero_i,

   output logic                  busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state;
   logic                  prio;      // requester preferred when both are valid
   logic                  owner;     // requester of the transaction in flight

   logic                  iss_funct7;
   logic [2:0]            iss_op;
   logic [2:0]            iss_funct3;
   logic [DATA_WIDTH-1:0] iss_a;
   logic [DATA_WIDTH-1:0] iss_b;

   logic [DATA_WIDTH-1:0] res_value;
   logic                  res_zero;

   logic                  idle;
   logic                  accept0;
   logic                  accept1;
   logic                  rsp_handshake;

   assign idle = (state == IDLE);

   // A requester only loses ready when the other side is valid and currently
   // preferred, so a lone requester is granted regardless of prio.
   assign req0_ready_o = idle & ~(req1_valid_i &  prio);
   assign req1_ready_o = idle & ~(req0_valid_i & ~prio);

   // Both readies are never high while both valids are high, so at most one
   // accept fires per cycle.
   assign accept0 = req0_valid_i & req0_ready_o;
   assign accept1 = req1_valid_i & req1_ready_o;

   assign rsp_handshake = (state == RESP) & (owner ? rsp1_ready_i : rsp0_ready_i);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         prio       <= 1'b0;
         owner      <= 1'b0;
         iss_funct7 <= 1'b0;
         iss_op     <= 3'd0;
         iss_funct3 <= 3'd0;
         iss_a      <= '0;
         iss_b      <= '0;
         res_value  <= '0;
         res_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept1) begin
                  owner      <= 1'b1;
                  iss_funct7 <= req1_funct7_i;
                  iss_op     <= req1_alu_op_i;
                  iss_funct3 <= req1_funct3_i;
                  iss_a      <= req1_a_i;
                  iss_b      <= req1_b_i;
                  state      <= EXEC;
               end else if (accept0) begin
                  owner      <= 1'b0;
                  iss_funct7 <= req0_funct7_i;
                  iss_op     <= req0_alu_op_i;
                  iss_funct3 <= req0_funct3_i;
                  iss_a      <= req0_a_i;
                  iss_b      <= req0_b_i;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               res_value <= alu_result_i;
               res_zero  <= alu_zero_i;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_handshake) begin
                  // Hand priority to the side that did not just finish.
                  prio  <= ~owner;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The issue register drives the ALU in every state. The ALU result is
   // only sampled in EXEC, so the value it computes elsewhere does not matter.
   assign alu_funct7_o = iss_funct7;
   assign alu_op_o     = iss_op;
   assign alu_funct3_o = iss_funct3;
   assign alu_a_o      = iss_a;
   assign alu_b_o      = iss_b;

   assign rsp0_valid_o  = (state == RESP) & ~owner;
   assign rsp1_valid_o  = (state == RESP) &  owner;
   assign rsp0_result_o = res_value;
   assign rsp1_result_o = res_value;
   assign rsp0_zero_o   = res_zero;
   assign rsp1_zero_o   = res_zero;

   assign busy_o = ~idle;

endmodule
